// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types and constants for the ID-stage interlock
package pipeline_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } hsu_state_t;

    localparam logic [4:0] REG_ZERO  = 5'd0;
    localparam int         DEF_CNT_W = 16;

    // True when a live producer writes a register the consumer actually reads.
    function automatic logic src_match(
        input logic [4:0] dst,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       uses_rs,
        input logic       uses_rt
    );
        return (dst != REG_ZERO) &&
               ((uses_rs && (dst == rs)) || (uses_rt && (dst == rt)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}};

    // Count events, holding at the maximum instead of wrapping.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != MAX_COUNT)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - ID-stage load-use / branch-operand interlock with perf counters
import pipeline_pkg::*;

module hazard_stall_unit #(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rs,
    input  logic             ifid_uses_rt,
    input  logic             ifid_is_branch,
    input  logic             ifid_taken,
    input  logic [4:0]       idex_rd,
    input  logic             idex_RegWrite,
    input  logic             idex_MemRead,
    input  logic [4:0]       exmem_rd,
    input  logic             exmem_MemRead,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEX_Bubble,
    output logic             IFID_Flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    hsu_state_t state, state_next;
    logic [1:0] remain, remain_next;
    logic [1:0] need;
    logic       match_e, match_m;
    logic       stall_raw, stall, flush;

    assign match_e = src_match(idex_rd,  ifid_rs, ifid_rt, ifid_uses_rs, ifid_uses_rt);
    assign match_m = src_match(exmem_rd, ifid_rs, ifid_rt, ifid_uses_rs, ifid_uses_rt);

    // Bubbles needed before the ID instruction can safely read its operands.
    always_comb begin
        need = 2'd0;
        if (idex_MemRead && match_e && ifid_is_branch) begin
            need = 2'd2;
        end else if (idex_MemRead && match_e) begin
            need = 2'd1;
        end else if (idex_RegWrite && !idex_MemRead && match_e && ifid_is_branch) begin
            need = 2'd1;
        end else if (exmem_MemRead && match_m && ifid_is_branch) begin
            need = 2'd1;
        end
    end

    // Next-state and stall decision; HOLD stalls unconditionally until remain runs out.
    always_comb begin
        state_next  = state;
        remain_next = remain;
        stall_raw   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (need != 2'd0) begin
                    stall_raw = 1'b1;
                    if (need == 2'd2) begin
                        state_next  = ST_HOLD;
                        remain_next = 2'd1;
                    end
                end
            end
            ST_HOLD: begin
                stall_raw   = 1'b1;
                remain_next = remain - 2'd1;
                if (remain == 2'd1) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next  = ST_IDLE;
                remain_next = 2'd0;
            end
        endcase
    end

    // Reset forces the pipeline to run freely; a stalled branch never flushes.
    assign stall = stall_raw && !Rst;
    assign flush = ifid_taken && !stall_raw && !Rst;

    assign PCWrite     = !stall;
    assign IFIDWrite   = !stall;
    assign IDEX_Bubble = stall;
    assign IFID_Flush  = flush;

    // FSM state register; reset aborts any hold in progress.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state  <= ST_IDLE;
            remain <= 2'd0;
        end else begin
            state  <= state_next;
            remain <= remain_next;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (Clk),
        .clear (Rst),
        .inc   (stall),
        .count (stall_cycles)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (Clk),
        .clear (Rst),
        .inc   (flush),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - scoreboard bench for hazard_stall_unit
module tb_hazard_stall_unit;

    logic        Clk;
    logic        Rst;
    logic [4:0]  ifid_rs, ifid_rt;
    logic        ifid_uses_rs, ifid_uses_rt;
    logic        ifid_is_branch, ifid_taken;
    logic [4:0]  idex_rd;
    logic        idex_RegWrite, idex_MemRead;
    logic [4:0]  exmem_rd;
    logic        exmem_MemRead;
    logic        PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush;
    logic [15:0] stall_cycles, flush_count;

    hazard_stall_unit #(.CNT_W(16)) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .ifid_rs        (ifid_rs),
        .ifid_rt        (ifid_rt),
        .ifid_uses_rs   (ifid_uses_rs),
        .ifid_uses_rt   (ifid_uses_rt),
        .ifid_is_branch (ifid_is_branch),
        .ifid_taken     (ifid_taken),
        .idex_rd        (idex_rd),
        .idex_RegWrite  (idex_RegWrite),
        .idex_MemRead   (idex_MemRead),
        .exmem_rd       (exmem_rd),
        .exmem_MemRead  (exmem_MemRead),
        .PCWrite        (PCWrite),
        .IFIDWrite      (IFIDWrite),
        .IDEX_Bubble    (IDEX_Bubble),
        .IFID_Flush     (IFID_Flush),
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
    );

    typedef struct {
        logic        stall;
        logic        flush;
        logic        chk;
        logic [15:0] sc;
        logic [15:0] fc;
        int          tag;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;
    int   vec_id   = 0;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Monitor: every cycle the DUT presents one response; compare it mid-cycle.
    always @(negedge Clk) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush} !==
                {~e.stall, ~e.stall, e.stall, e.flush}) begin
                failures++;
                $display("FAIL outputs vec%0d: got PCWrite=%b IFIDWrite=%b IDEX_Bubble=%b IFID_Flush=%b, want stall=%b flush=%b",
                         e.tag, PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, e.stall, e.flush);
            end
            if (e.chk) begin
                checks++;
                if (stall_cycles !== e.sc || flush_count !== e.fc) begin
                    failures++;
                    $display("FAIL counters vec%0d: got stall_cycles=%0d flush_count=%0d, want %0d %0d",
                             e.tag, stall_cycles, flush_count, e.sc, e.fc);
                end
            end
        end
    end

    // Apply one cycle of inputs just after the edge and queue the expected response.
    task automatic drv(
        input logic       rst,
        input logic [4:0] rs, input logic [4:0] rt,
        input logic       urs, input logic urt,
        input logic       br,  input logic tk,
        input logic [4:0] idrd, input logic idrw, input logic idmr,
        input logic [4:0] exrd, input logic exmr,
        input logic       x_stall, input logic x_flush,
        input logic       chk, input logic [15:0] sc, input logic [15:0] fc
    );
        exp_t x;
        @(posedge Clk);
        #1;
        Rst = rst;
        ifid_rs = rs; ifid_rt = rt; ifid_uses_rs = urs; ifid_uses_rt = urt;
        ifid_is_branch = br; ifid_taken = tk;
        idex_rd = idrd; idex_RegWrite = idrw; idex_MemRead = idmr;
        exmem_rd = exrd; exmem_MemRead = exmr;
        x.stall = x_stall; x.flush = x_flush; x.chk = chk;
        x.sc = sc; x.fc = fc; x.tag = vec_id;
        vec_id++;
        sb.push_back(x);
    endtask

    initial begin
        int wait_cnt;
        Rst = 1'b1;
        ifid_rs = 0; ifid_rt = 0; ifid_uses_rs = 0; ifid_uses_rt = 0;
        ifid_is_branch = 0; ifid_taken = 0;
        idex_rd = 0; idex_RegWrite = 0; idex_MemRead = 0;
        exmem_rd = 0; exmem_MemRead = 0;

        //   rst rs rt urs urt br tk idrd rw mr exrd mr | stall flush chk sc fc
        // Reset: outputs forced free-running, counters cleared (after first edge).
        drv(1, 8, 8, 1, 1, 1, 1, 8, 1, 1, 8, 1,  0, 0, 0, 0, 0);
        drv(1, 8, 8, 1, 1, 1, 1, 8, 1, 1, 8, 1,  0, 0, 1, 0, 0);
        // Load-use: lw $8 in EX, add reads $8 -> one stall.
        drv(0, 8, 9, 1, 1, 0, 0, 8, 1, 1, 0, 0,  1, 0, 1, 0, 0);
        drv(0, 8, 9, 1, 1, 0, 0, 0, 0, 0, 8, 1,  0, 0, 1, 1, 0);
        // Load-branch: beq $8 taken -> two stalls, then flush.
        drv(0, 8, 0, 1, 1, 1, 1, 8, 1, 1, 0, 0,  1, 0, 1, 1, 0);
        drv(0, 8, 0, 1, 1, 1, 1, 0, 0, 0, 8, 1,  1, 0, 1, 2, 0);
        drv(0, 8, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0,  0, 1, 1, 3, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 3, 1);
        // ALU result into bne -> one stall; same producer into R-type -> none.
        drv(0,10, 9, 1, 1, 1, 0, 9, 1, 0, 0, 0,  1, 0, 1, 3, 1);
        drv(0,10, 9, 1, 1, 1, 0, 0, 0, 0, 9, 0,  0, 0, 1, 4, 1);
        drv(0,10, 9, 1, 1, 0, 0, 9, 1, 0, 0, 0,  0, 0, 1, 4, 1);
        // Register 0 never hazards; unstalled taken jump flushes.
        drv(0, 0, 0, 1, 1, 0, 1, 0, 1, 1, 0, 1,  0, 1, 1, 4, 1);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 4, 2);
        // Load in MEM feeding a branch -> one stall.
        drv(0, 7, 0, 1, 0, 1, 0, 0, 0, 0, 7, 1,  1, 0, 1, 4, 2);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 5, 2);
        // Matching register that is not actually read -> no stall.
        drv(0, 8, 3, 0, 1, 0, 0, 8, 1, 1, 0, 0,  0, 0, 1, 5, 2);
        // Reset on the HOLD cycle of a load-branch aborts the hold.
        drv(0, 8, 0, 1, 1, 1, 1, 8, 1, 1, 0, 0,  1, 0, 1, 5, 2);
        drv(1, 8, 0, 1, 1, 1, 1, 0, 0, 0, 8, 1,  0, 0, 1, 6, 2);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0);
        // Saturation: 65537 consecutive load-use stalls.
        for (int i = 0; i < 65537; i++) begin
            drv(0, 8, 9, 1, 1, 0, 0, 8, 1, 1, 0, 0,  1, 0, 1,
                (i > 65535) ? 16'hFFFF : 16'(i), 0);
        end
        drv(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,  0, 1, 1, 16'hFFFF, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 16'hFFFF, 1);

        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 10) begin
            @(posedge Clk);
            wait_cnt++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Interlock controller in the ID stage of the 5-stage MIPS pipeline; the stall/flush counterpart to EX-stage forwarding. Detects hazards that forwarding into EX cannot cover: load-use, and branches resolved in ID whose operands are still in flight. Drives PC/IF-ID write enables, ID/EX bubble insertion, and IF/ID flush on taken control transfers. Keeps saturating stall/flush counters for performance reporting.

## Interface
- CNT_W, 16, width of each performance counter
- Clk  input  1  pipeline clock; all state updates on rising edge
- Rst  input  1  synchronous, active-high reset
- ifid_rs / ifid_rt  input  5 each  source registers of the instruction in ID
- ifid_uses_rs / ifid_uses_rt  input  1 each  instruction actually reads that source
- ifid_is_branch  input  1  instruction in ID compares registers in ID (beq/bne/blez/bgtz/bltz/bgez, jr)
- ifid_taken  input  1  control transfer in ID redirects the PC (taken branch, j, jal, jr)
- idex_rd  input  5  destination register (post-RegDst mux) of instruction in EX
- idex_RegWrite / idex_MemRead  input  1 each  control bits of instruction in EX
- exmem_rd  input  5  destination register of instruction in MEM
- exmem_MemRead  input  1  instruction in MEM is a load
- PCWrite  output  1  PC load enable
- IFIDWrite  output  1  IF/ID register load enable
- IDEX_Bubble  output  1  zero ID/EX control bits this cycle
- IFID_Flush  output  1  clear IF/ID to nop on next edge
- stall_cycles  output  CNT_W  cycles with stall asserted, saturating
- flush_count  output  CNT_W  flushes issued, saturating

## Operation
- matchE: idex_rd != 0 and ((uses_rs and idex_rd == ifid_rs) or (uses_rt and idex_rd == ifid_rt)); matchM is the same using exmem_rd.
- Needed stall count n, evaluated in IDLE:
  - idex_MemRead and matchE and is_branch -> 2.
  - idex_MemRead and matchE -> 1.
  - idex_RegWrite and not idex_MemRead and matchE and is_branch -> 1.
  - exmem_MemRead and matchM and is_branch -> 1.
  - Otherwise 0. Take the first rule that matches.
- FSM states: IDLE, HOLD. 2-bit down-counter `remain`.
  - IDLE, n = 0: no stall.
  - IDLE, n >= 1: stall asserted this cycle. If n = 2, go to HOLD with remain = 1; else stay in IDLE.
  - HOLD: stall asserted regardless of inputs. Decrement remain; at remain = 1, return to IDLE.
- Stall asserted: PCWrite = 0, IFIDWrite = 0, IDEX_Bubble = 1.
- Stall deasserted: PCWrite = 1, IFIDWrite = 1, IDEX_Bubble = 0.
- IFID_Flush = ifid_taken and not stall. A stalled branch has stale operands and its outcome is ignored.
- Counters:
  - stall_cycles increments on each stalled cycle.
  - flush_count increments on each cycle with IFID_Flush = 1.
  - Both saturate at 2^CNT_W - 1.
- Register 0 never causes a hazard.

## Timing
- Stall and flush outputs are combinational from state and inputs, valid in the same cycle as detection. Zero latency.
- Counters are registered and reflect an event one cycle after it occurs.
- Reset value / behaviour while Rst = 1:
  - State IDLE, remain = 0, counters 0.
  - PCWrite = 1, IFIDWrite = 1, IDEX_Bubble = 0, IFID_Flush = 0, all forced.
- Reset asserted during HOLD aborts the hold. The first cycle after reset evaluates hazards fresh.
- Load-branch case: 2 consecutive stall cycles, then the branch resolves in ID with the load result written back (register file is write-first).
- Simultaneous hazard and ifid_taken: the stall wins and no flush is issued. The flush happens on the first unstalled cycle if the branch is still taken.
- Counter saturation: the value holds at max; no wrap.

## Structure
- Shared package `pipeline_pkg`:
  - FSM state encodings (IDLE = 0, HOLD = 1).
  - REG_ZERO = 5'd0.
  - Default CNT_W.
- One sub-module, `sat_counter` (param width, inputs inc/clear, output count), instantiated twice for the performance counters.

## Test plan
- lw $t0 in EX (idex_MemRead = 1, idex_rd = 8); add in ID reads rs = 8 -> exactly 1 cycle with PCWrite = 0, IDEX_Bubble = 1; stall_cycles = 1.
- lw rd = 8 in EX; beq rs = 8 in ID -> 2 consecutive stall cycles (IDLE -> HOLD -> IDLE); stall_cycles = 2; no flush during the stall.
- add rd = 9 in EX (RegWrite = 1, MemRead = 0); bne rt = 9 in ID -> 1 stall; identical add with an R-type consumer -> 0 stalls (forwarding covers it).
- idex_rd = 0 with MemRead = 1 and ifid_rs = 0 -> no stall; ifid_taken = 1 unstalled -> IFID_Flush = 1, flush_count = 1.
- Rst = 1 on the HOLD cycle of a load-branch stall -> outputs PCWrite = 1, IDEX_Bubble = 0, counters 0, state IDLE next cycle.
- Force 65 535 stall cycles with CNT_W = 16, then one more -> stall_cycles stays 16'hFFFF.
